// File: rtl/updowncount_pkg.sv
// Shared encodings for the loadable up/down counter: direction constants and
// the per-edge operation selected from load/enable/direction.
package updowncount_pkg;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_DOWN = 2'd1,
    OP_UP   = 2'd2,
    OP_LOAD = 2'd3
  } op_e;

  // Load beats count; count direction only matters when enabled.
  function automatic op_e sel_op(input logic l, input logic e, input logic up_down);
    op_e op;
    op = OP_HOLD;
    if (l)
      op = OP_LOAD;
    else if (e && (up_down == UP))
      op = OP_UP;
    else if (e && (up_down == DOWN))
      op = OP_DOWN;
    return op;
  endfunction

endpackage

// File: rtl/updowncount.sv
// n-bit synchronous up/down counter with synchronous parallel load, count
// enable and asynchronous active-low clear. Wraps modulo 2^n in both directions.
module updowncount
  import updowncount_pkg::*;
#(
  parameter int n = 8
) (
  input  logic [n-1:0] R,
  input  logic         Resetn,
  input  logic         Clock,
  input  logic         E,
  input  logic         up_down,
  input  logic         L,
  output logic [n-1:0] Q
);

  function automatic logic [n-1:0] next_q(input op_e op, input logic [n-1:0] q,
                                          input logic [n-1:0] r);
    logic [n-1:0] nq;
    nq = q;
    case (op)
      OP_LOAD: nq = r;
      OP_UP:   nq = q + n'(1);
      OP_DOWN: nq = q - n'(1);
      default: nq = q;
    endcase
    return nq;
  endfunction

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      Q <= '0;
    else
      Q <= next_q(sel_op(L, E, up_down), Q, R);
  end

endmodule

// File: tb/tb_updowncount.sv
// Self-checking bench for updowncount: directed scenarios followed by random
// load/count/hold traffic with occasional asynchronous clears, against an
// arithmetic reference model.
module tb_updowncount;

  logic [7:0] R;
  logic       Resetn;
  logic       Clock;
  logic       E;
  logic       up_down;
  logic       L;
  logic [7:0] Q;

  int model;
  int errors;
  int checks;

  updowncount #(.n(8)) dut (
    .R       (R),
    .Resetn  (Resetn),
    .Clock   (Clock),
    .E       (E),
    .up_down (up_down),
    .L       (L),
    .Q       (Q)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one set of inputs, take one rising edge, advance the model and
  // leave time 1 unit past the edge for sampling.
  task automatic step(input logic l_i, input logic e_i, input logic ud_i, input logic [7:0] r_i);
    L = l_i;
    E = e_i;
    up_down = ud_i;
    R = r_i;
    @(posedge Clock);
    if (l_i)
      model = r_i;
    else if (e_i && ud_i)
      model = (model + 1) % 256;
    else if (e_i)
      model = (model + 255) % 256;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    errors  = 0;
    checks  = 0;
    model   = 0;
    Resetn  = 1'b0;
    E       = 1'b1;
    L       = 1'b0;
    up_down = 1'b1;
    R       = 8'h00;

    // Held in reset with counting enabled: must stay at zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock);
      #1;
      check("reset_hold", Q, 8'h00);
    end
    Resetn = 1'b1;

    step(1'b0, 1'b1, 1'b1, 8'h00);
    check("first_count", Q, 8'h01);

    step(1'b1, 1'b1, 1'b1, 8'h0D);
    check("load_priority", Q, 8'h0D);

    step(1'b0, 1'b1, 1'b1, 8'h00);
    check("up_0e", Q, 8'h0E);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check("up_0f", Q, 8'h0F);

    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, logic'(i[0]), 8'hA5);
      check("hold", Q, 8'h0F);
    end

    step(1'b1, 1'b0, 1'b0, 8'h01);
    check("load_01", Q, 8'h01);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("down_00", Q, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("underflow_ff", Q, 8'hFF);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("down_fe", Q, 8'hFE);

    step(1'b1, 1'b0, 1'b1, 8'hFE);
    check("load_fe", Q, 8'hFE);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check("up_ff", Q, 8'hFF);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check("overflow_00", Q, 8'h00);

    // Async clear between edges while counting, then load attempted under reset.
    step(1'b1, 1'b0, 1'b1, 8'h0F);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    check("pre_async", Q, 8'h10);
    #3;
    Resetn = 1'b0;
    model  = 0;
    #1;
    check("async_clear", Q, 8'h00);
    L = 1'b1;
    R = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock);
      #1;
      check("reset_ignores_load", Q, 8'h00);
    end
    Resetn = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("after_release_down", Q, 8'hFF);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        #2;
        Resetn = 1'b0;
        model  = 0;
        #1;
        check("rand_async_clear", Q, 8'h00);
        Resetn = 1'b1;
      end else begin
        step(logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        check("rand", Q, 8'(model));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
